// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer, its program counter and program ROM.
// The sequencer side is the master: it drives the counter controls and decoded instruction.
interface fetch_sequencer_if;
  logic        go;
  logic        hold;
  logic [7:0]  prog_byte;
  logic [11:0] pc_in;
  logic        pc_en;
  logic        pc_load;
  logic [11:0] pc_data;
  logic [3:0]  instr;
  logic [3:0]  oprnd;
  logic        instr_valid;
  logic        jump_done;
  logic        self_jump;

  modport master (
    input  go, hold, prog_byte, pc_in,
    output pc_en, pc_load, pc_data, instr, oprnd, instr_valid, jump_done, self_jump
  );

  modport slave (
    output go, hold, prog_byte, pc_in,
    input  pc_en, pc_load, pc_data, instr, oprnd, instr_valid, jump_done, self_jump
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program fetch sequencer: steps an external counter through ROM, decodes one-byte
// instructions and two-byte jumps, and flags jumps that target their own address.
module fetch_sequencer #(
  parameter logic [3:0] JMP_OP = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    JMP_LO = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  addr_hi, addr_hi_nxt;
  logic [11:0] jmp_addr, jmp_addr_nxt;
  logic [3:0]  instr_q, instr_nxt;
  logic [3:0]  oprnd_q, oprnd_nxt;
  logic        instr_valid_q, instr_valid_nxt;
  logic        jump_done_q, jump_done_nxt;
  logic        self_jump_q, self_jump_nxt;
  logic        pc_en_c, pc_load_c;
  logic [11:0] pc_data_c;
  logic        is_jmp;
  logic [11:0] jmp_target;

  assign is_jmp     = (bus.prog_byte[7:4] == JMP_OP);
  assign jmp_target = {addr_hi, bus.prog_byte};

  always_comb begin
    state_nxt       = state;
    addr_hi_nxt     = addr_hi;
    jmp_addr_nxt    = jmp_addr;
    instr_nxt       = instr_q;
    oprnd_nxt       = oprnd_q;
    instr_valid_nxt = 1'b0;
    jump_done_nxt   = 1'b0;
    self_jump_nxt   = self_jump_q;
    pc_en_c         = 1'b0;
    pc_load_c       = 1'b0;
    pc_data_c       = 12'h000;

    if (!bus.hold) begin
      case (state)
        IDLE: begin
          if (bus.go) state_nxt = FETCH;
        end
        FETCH: begin
          pc_en_c = 1'b1;
          if (is_jmp) begin
            // First byte of a jump: remember the high nibble and where the jump lives.
            addr_hi_nxt  = bus.prog_byte[3:0];
            jmp_addr_nxt = bus.pc_in;
            state_nxt    = JMP_LO;
          end else begin
            instr_nxt       = bus.prog_byte[7:4];
            oprnd_nxt       = bus.prog_byte[3:0];
            instr_valid_nxt = 1'b1;
            state_nxt       = bus.go ? FETCH : IDLE;
          end
        end
        JMP_LO: begin
          // The jump always completes once started; go only decides what follows.
          pc_load_c     = 1'b1;
          pc_data_c     = jmp_target;
          jump_done_nxt = 1'b1;
          if (jmp_target == jmp_addr) self_jump_nxt = 1'b1;
          state_nxt     = bus.go ? FETCH : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      addr_hi       <= 4'h0;
      jmp_addr      <= 12'h000;
      instr_q       <= 4'h0;
      oprnd_q       <= 4'h0;
      instr_valid_q <= 1'b0;
      jump_done_q   <= 1'b0;
      self_jump_q   <= 1'b0;
    end else begin
      state         <= state_nxt;
      addr_hi       <= addr_hi_nxt;
      jmp_addr      <= jmp_addr_nxt;
      instr_q       <= instr_nxt;
      oprnd_q       <= oprnd_nxt;
      instr_valid_q <= instr_valid_nxt;
      jump_done_q   <= jump_done_nxt;
      self_jump_q   <= self_jump_nxt;
    end
  end

  // Counter controls are forced low for the whole time reset is held.
  assign bus.pc_en       = reset & pc_en_c;
  assign bus.pc_load     = reset & pc_load_c;
  assign bus.pc_data     = reset ? pc_data_c : 12'h000;
  assign bus.instr       = instr_q;
  assign bus.oprnd       = oprnd_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.jump_done   = jump_done_q;
  assign bus.self_jump   = self_jump_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural program counter and ROM.
module tb_fetch_sequencer;
  logic        clk;
  logic        reset;
  logic        pc_set;
  logic [11:0] pc_set_val;
  logic [11:0] pc;
  logic [7:0]  rom [0:4095];
  int          n_assert;
  int          n_fail;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.JMP_OP(4'hF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pc_set)           pc <= pc_set_val;
    else if (bus.pc_load) pc <= bus.pc_data;
    else if (bus.pc_en)   pc <= pc + 12'd1;
  end

  assign bus.prog_byte = rom[pc];
  assign bus.pc_in     = pc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preset(input logic [11:0] a);
    pc_set     = 1'b1;
    pc_set_val = a;
    tick();
    pc_set     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h000] = 8'h23; rom[12'h001] = 8'h45; rom[12'h002] = 8'h67;
    rom[12'h005] = 8'hF1; rom[12'h006] = 8'h2A;
    rom[12'h010] = 8'hF0; rom[12'h011] = 8'h10;
    rom[12'h020] = 8'hF3; rom[12'h021] = 8'h44;

    reset = 1'b0; bus.go = 1'b0; bus.hold = 1'b0;
    pc_set = 1'b1; pc_set_val = 12'h000;
    tick(); tick();
    check("rst_pc_en",   bus.pc_en, 0);
    check("rst_pc_load", bus.pc_load, 0);
    check("rst_pc_data", bus.pc_data, 0);
    check("rst_instr",   bus.instr, 0);
    check("rst_oprnd",   bus.oprnd, 0);
    check("rst_ivalid",  bus.instr_valid, 0);
    check("rst_jdone",   bus.jump_done, 0);
    check("rst_selfj",   bus.self_jump, 0);

    // Linear fetch of three one-byte instructions
    reset = 1'b1; pc_set = 1'b0;
    tick();
    bus.go = 1'b1; #1;
    check("lin_idle_pc_en", bus.pc_en, 0);
    tick();
    check("lin_f0_pc_en",   bus.pc_en, 1);
    check("lin_f0_pc_load", bus.pc_load, 0);
    check("lin_f0_ivalid",  bus.instr_valid, 0);
    tick();
    check("lin_i0_instr",  bus.instr, 4'h2);
    check("lin_i0_oprnd",  bus.oprnd, 4'h3);
    check("lin_i0_ivalid", bus.instr_valid, 1);
    check("lin_f1_pc_en",  bus.pc_en, 1);
    tick();
    check("lin_i1_instr",  bus.instr, 4'h4);
    check("lin_i1_oprnd",  bus.oprnd, 4'h5);
    check("lin_i1_ivalid", bus.instr_valid, 1);
    bus.go = 1'b0; #1;
    check("lin_f2_pc_en", bus.pc_en, 1);
    tick();
    check("lin_i2_instr",  bus.instr, 4'h6);
    check("lin_i2_oprnd",  bus.oprnd, 4'h7);
    check("lin_i2_ivalid", bus.instr_valid, 1);
    check("lin_stop_pc_en", bus.pc_en, 0);
    check("lin_pc", pc, 12'h003);
    tick();
    check("lin_ivalid_clr", bus.instr_valid, 0);

    // Two-byte jump to 12'h12A
    preset(12'h005);
    bus.go = 1'b1;
    tick();
    check("jmp_hi_pc_en",   bus.pc_en, 1);
    check("jmp_hi_pc_load", bus.pc_load, 0);
    tick();
    check("jmp_lo_ivalid",  bus.instr_valid, 0);
    check("jmp_lo_pc_load", bus.pc_load, 1);
    check("jmp_lo_pc_en",   bus.pc_en, 0);
    check("jmp_lo_pc_data", bus.pc_data, 12'h12A);
    tick();
    check("jmp_done",       bus.jump_done, 1);
    check("jmp_pc",         pc, 12'h12A);
    check("jmp_ivalid",     bus.instr_valid, 0);
    check("jmp_instr_keep", bus.instr, 4'h6);
    bus.go = 1'b0;
    tick();
    check("jmp_done_clr",  bus.jump_done, 0);
    check("jmp_next_instr", bus.instr, 4'h0);

    // Hold during JMP_LO with go dropping mid-jump
    preset(12'h020);
    bus.go = 1'b1;
    tick();
    tick();
    bus.hold = 1'b1; bus.go = 1'b0; #1;
    check("hold_pc_load", bus.pc_load, 0);
    check("hold_pc_en",   bus.pc_en, 0);
    check("hold_pc_data", bus.pc_data, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_cyc_pc_load", bus.pc_load, 0);
      check("hold_cyc_jdone",   bus.jump_done, 0);
      check("hold_cyc_pc",      pc, 12'h021);
    end
    bus.hold = 1'b0; #1;
    check("hold_rel_pc_load", bus.pc_load, 1);
    check("hold_rel_pc_data", bus.pc_data, 12'h344);
    tick();
    check("stop_jdone", bus.jump_done, 1);
    check("stop_pc",    pc, 12'h344);
    check("stop_pc_en", bus.pc_en, 0);
    tick();
    check("stop_idle_pc_en", bus.pc_en, 0);
    check("stop_idle_pc",    pc, 12'h344);

    // Jump whose target is its own first byte
    check("selfj_before", bus.self_jump, 0);
    preset(12'h010);
    bus.go = 1'b1;
    tick();
    tick();
    check("selfj_pc_load", bus.pc_load, 1);
    check("selfj_pc_data", bus.pc_data, 12'h010);
    bus.go = 1'b0;
    tick();
    check("selfj_set", bus.self_jump, 1);
    check("selfj_pc",  pc, 12'h010);
    tick(); tick(); tick();
    check("selfj_sticky", bus.self_jump, 1);

    // Reset asserted in JMP_LO discards the jump
    preset(12'h020);
    bus.go = 1'b1;
    tick();
    tick();
    check("rstj_pc_load_pre", bus.pc_load, 1);
    reset = 1'b0; bus.go = 1'b0; #1;
    check("rstj_pc_load", bus.pc_load, 0);
    check("rstj_pc_data", bus.pc_data, 0);
    check("rstj_pc_en",   bus.pc_en, 0);
    check("rstj_selfj",   bus.self_jump, 0);
    check("rstj_instr",   bus.instr, 0);
    check("rstj_ivalid",  bus.instr_valid, 0);
    tick();
    check("rstj_pc_hold", pc, 12'h021);
    reset = 1'b1;
    tick();
    check("rstj_rel_pc_load", bus.pc_load, 0);
    check("rstj_rel_pc_en",   bus.pc_en, 0);
    bus.go = 1'b1; #1;
    check("rstj_go_idle_pc_en", bus.pc_en, 0);
    tick();
    check("rstj_resume_pc_en", bus.pc_en, 1);
    check("rstj_resume_pc",    pc, 12'h021);
    tick();
    check("rstj_resume_instr",  bus.instr, 4'h4);
    check("rstj_resume_oprnd",  bus.oprnd, 4'h4);
    check("rstj_resume_ivalid", bus.instr_valid, 1);
    check("rstj_no_jdone",      bus.jump_done, 0);
    bus.go = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
